// File: rtl/fft_pkg.sv
// Shared types and sizing helpers for the radix-2 FFT stage sequencer.
package fft_pkg;

    localparam int LOG2N_DEF    = 3;
    localparam int PIPE_LAT_DEF = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;

    function automatic int stage_w(input int log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

    function automatic int cnt_w(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/fft_stage_ctrl_if.sv
// Control/address bundle between the FFT sequencer and its host/datapath.
interface fft_stage_ctrl_if import fft_pkg::*; #(
    parameter int LOG2N = LOG2N_DEF
) ();
    localparam int SW = stage_w(LOG2N);

    logic             start;
    logic             hold;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;
    logic [SW-1:0]    stage;

    modport slave (
        input  start, hold,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b, stage
    );

    modport master (
        output start, hold,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b, stage
    );
endinterface

// File: rtl/fft_ctrl_delay.sv
// Fixed-depth shift register turning issued read pairs into write-back strobes.
module fft_ctrl_delay #(
    parameter int W     = 7,
    parameter int DEPTH = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [DEPTH-1:0][W-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/fft_stage_ctrl.sv
// In-place radix-2 DIT FFT sequencer: walks stages/butterflies, issues pair and
// twiddle addresses, and separates stages with a flush gap of PIPE_LAT cycles.
module fft_stage_ctrl import fft_pkg::*; #(
    parameter int LOG2N    = LOG2N_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    fft_stage_ctrl_if.slave bus
);
    localparam int AW = LOG2N;
    localparam int JW = LOG2N - 1;
    localparam int SW = stage_w(LOG2N);
    localparam int CW = cnt_w(PIPE_LAT);
    localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(PIPE_LAT - 1);

    state_t        state, state_nx;
    logic [JW-1:0] j, j_nx;
    logic [SW-1:0] stg, stg_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          issue, done_nx;

    logic [JW-1:0] mask, k, tw;
    logic [AW-1:0] addr_a, addr_b;

    logic          rd_en_q, busy_q, done_q;
    logic [AW-1:0] rd_a_q, rd_b_q;
    logic [JW-1:0] tw_q;

    // mask = h-1 computed in JW bits; at the last stage h overflows to 0 and the
    // mask correctly becomes all ones (k = j, no group bits).
    always_comb begin
        mask   = ~({JW{1'b1}} << stg);
        k      = j & mask;
        addr_a = {(j & ~mask), 1'b0} | {1'b0, k};
        addr_b = addr_a | (AW'(1) << stg);
        tw     = k << (LOG2N - 1 - int'(stg));
    end

    always_comb begin
        state_nx = state;
        j_nx     = j;
        stg_nx   = stg;
        cnt_nx   = cnt;
        issue    = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                state_nx = ISSUE;
                j_nx     = '0;
                stg_nx   = '0;
            end
            ISSUE: if (!bus.hold) begin
                issue = 1'b1;
                if (j == {JW{1'b1}}) begin
                    state_nx = FLUSH;
                    cnt_nx   = '0;
                end else begin
                    j_nx = j + 1'b1;
                end
            end
            FLUSH: begin
                if (cnt == LAST_CNT) begin
                    if (stg == LAST_STAGE) begin
                        state_nx = DONE;
                    end else begin
                        stg_nx   = stg + 1'b1;
                        j_nx     = '0;
                        state_nx = ISSUE;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            j       <= '0;
            stg     <= '0;
            cnt     <= '0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            j       <= j_nx;
            stg     <= stg_nx;
            cnt     <= cnt_nx;
            rd_en_q <= issue;
            busy_q  <= (state != IDLE);
            done_q  <= done_nx;
            // addresses only move on issue so idle/hold cycles don't toggle them
            if (issue) begin
                rd_a_q <= addr_a;
                rd_b_q <= addr_b;
                tw_q   <= tw;
            end
        end
    end

    fft_ctrl_delay #(.W(2*AW+1), .DEPTH(PIPE_LAT)) u_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({rd_en_q, rd_a_q, rd_b_q}),
        .dout ({bus.wr_en, bus.wr_addr_a, bus.wr_addr_b})
    );

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = rd_a_q;
    assign bus.rd_addr_b = rd_b_q;
    assign bus.tw_addr   = tw_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stage     = stg;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl: a reference schedule is queued when each
// start is driven and consumed cycle by cycle as the sequencer emits strobes.
module tb_fft_stage_ctrl;

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int st;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   sel;
    int   errors;
    int   checks;
    int   base;
    int   t_done;
    int   t_st1;

    ev_t rdq[$];
    ev_t wrq[$];
    bit  hold_map  [0:1023];
    bit  start_map [0:1023];
    bit  done_map  [0:1023];
    bit  busy_map  [0:1023];

    logic [31:0] o_rd, o_a, o_b, o_tw, o_st, o_wr, o_wa, o_wb, o_done, o_busy;

    fft_stage_ctrl_if #(.LOG2N(3)) b0 ();
    fft_stage_ctrl_if #(.LOG2N(4)) b1 ();

    fft_stage_ctrl #(.LOG2N(3), .PIPE_LAT(3)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    fft_stage_ctrl #(.LOG2N(4), .PIPE_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Reference schedule built from group/offset enumeration of each stage.
    task automatic plan_run(input int b, input int L, input int P, input int cut);
        int n, h, t, dn;
        ev_t e;
        n = 1 << L;
        t = b + 1;
        for (int s = 0; s < L; s++) begin
            h = 1 << s;
            for (int g = 0; g < n / (2 * h); g++) begin
                for (int kk = 0; kk < h; kk++) begin
                    while (hold_map[t]) t++;
                    e.cyc = t;
                    e.a   = g * 2 * h + kk;
                    e.b   = e.a + h;
                    e.tw  = kk * (n / (2 * h));
                    e.st  = s;
                    if (t < cut) rdq.push_back(e);
                    e.cyc = t + P;
                    if (e.cyc < cut) wrq.push_back(e);
                    t++;
                end
            end
            t += P;
        end
        dn = t;
        if (dn < cut) done_map[dn] = 1'b1;
        for (int c = b + 1; c <= dn && c < cut; c++) busy_map[c] = 1'b1;
    endtask

    task automatic sample();
        if (sel == 0) begin
            o_rd = 32'(b0.rd_en);     o_a  = 32'(b0.rd_addr_a); o_b  = 32'(b0.rd_addr_b);
            o_tw = 32'(b0.tw_addr);   o_st = 32'(b0.stage);     o_wr = 32'(b0.wr_en);
            o_wa = 32'(b0.wr_addr_a); o_wb = 32'(b0.wr_addr_b); o_done = 32'(b0.done);
            o_busy = 32'(b0.busy);
        end else begin
            o_rd = 32'(b1.rd_en);     o_a  = 32'(b1.rd_addr_a); o_b  = 32'(b1.rd_addr_b);
            o_tw = 32'(b1.tw_addr);   o_st = 32'(b1.stage);     o_wr = 32'(b1.wr_en);
            o_wa = 32'(b1.wr_addr_a); o_wb = 32'(b1.wr_addr_b); o_done = 32'(b1.done);
            o_busy = 32'(b1.busy);
        end
    endtask

    task automatic check_cycle();
        bit  exp_rd, exp_wr;
        ev_t e;
        sample();
        exp_rd = (rdq.size() != 0) && (rdq[0].cyc == cyc);
        chk("rd_en", o_rd, 32'(exp_rd));
        if (exp_rd) begin
            e = rdq.pop_front();
            if (o_rd === 32'd1) begin
                chk("rd_addr_a", o_a, e.a);
                chk("rd_addr_b", o_b, e.b);
                chk("tw_addr", o_tw, e.tw);
                chk("stage", o_st, e.st);
            end
        end
        exp_wr = (wrq.size() != 0) && (wrq[0].cyc == cyc);
        chk("wr_en", o_wr, 32'(exp_wr));
        if (exp_wr) begin
            e = wrq.pop_front();
            if (o_wr === 32'd1) begin
                chk("wr_addr_a", o_wa, e.a);
                chk("wr_addr_b", o_wb, e.b);
            end
        end
        chk("done", o_done, 32'(done_map[cyc]));
        chk("busy", o_busy, 32'(busy_map[cyc]));
        if (o_done === 32'd1 && t_done < 0) t_done = cyc;
        if (o_rd === 32'd1 && o_st === 32'd1 && t_st1 < 0) t_st1 = cyc;
    endtask

    task automatic step();
        b0.start = (sel == 0) && start_map[cyc+1];
        b1.start = (sel == 1) && start_map[cyc+1];
        b0.hold  = hold_map[cyc+1];
        b1.hold  = hold_map[cyc+1];
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_rdq_left"}, rdq.size(), 0);
        chk({tag, "_wrq_left"}, wrq.size(), 0);
    endtask

    task automatic new_run(input int when_rel);
        base   = cyc + 1 + when_rel;
        t_done = -1;
        t_st1  = -1;
        start_map[base] = 1'b1;
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; sel = 0;
        rst_n  = 1'b0;
        b0.start = 1'b0; b0.hold = 1'b0;
        b1.start = 1'b0; b1.hold = 1'b0;
        t_done = -1; t_st1 = -1;

        // reset state
        repeat (2) step();
        sample();
        chk("rst_rd_a", o_a, 0);   chk("rst_rd_b", o_b, 0);  chk("rst_tw", o_tw, 0);
        chk("rst_stage", o_st, 0); chk("rst_wr_a", o_wa, 0); chk("rst_wr_b", o_wb, 0);
        chk("rst_b1_busy", 32'(b1.busy), 0);
        rst_n = 1'b1;
        repeat (2) step();

        // plain N=8 run
        new_run(0);
        plan_run(base, 3, 3, 1 << 30);
        repeat (24) step();
        chk("n8_done_cycle", t_done - base, 22);
        chk("n8_first_stage1_rd", t_st1 - base, 8);
        chk_drained("n8");

        // hold over cycles 2..4 of stage 0
        new_run(0);
        for (int c = 2; c <= 4; c++) hold_map[base + c] = 1'b1;
        plan_run(base, 3, 3, 1 << 30);
        repeat (27) step();
        chk("hold_done_cycle", t_done - base, 25);
        chk_drained("hold");

        // starts while busy are dropped; a start right after done is accepted
        new_run(0);
        start_map[base + 5]  = 1'b1;
        start_map[base + 22] = 1'b1;
        start_map[base + 23] = 1'b1;
        plan_run(base, 3, 3, 1 << 30);
        plan_run(base + 23, 3, 3, 1 << 30);
        repeat (47) step();
        chk("restart_first_done", t_done - base, 22);
        chk_drained("restart");

        // asynchronous reset in the middle of stage 1
        new_run(0);
        plan_run(base, 3, 3, base + 10);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        sample();
        chk("mid_rst_rd_en", o_rd, 0);  chk("mid_rst_rd_a", o_a, 0);  chk("mid_rst_rd_b", o_b, 0);
        chk("mid_rst_tw", o_tw, 0);     chk("mid_rst_wr_en", o_wr, 0); chk("mid_rst_wr_a", o_wa, 0);
        chk("mid_rst_wr_b", o_wb, 0);   chk("mid_rst_busy", o_busy, 0); chk("mid_rst_done", o_done, 0);
        chk("mid_rst_stage", o_st, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) step();
        chk_drained("mid_rst");

        // full run after the aborted one
        new_run(0);
        plan_run(base, 3, 3, 1 << 30);
        repeat (24) step();
        chk("post_rst_done_cycle", t_done - base, 22);
        chk_drained("post_rst");

        // N=16, PIPE_LAT=1 instance
        sel = 1;
        new_run(0);
        plan_run(base, 4, 1, 1 << 30);
        repeat (40) step();
        chk("n16_done_cycle", t_done - base, 37);
        chk_drained("n16");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_stage_ctrl.md
Name: fft_stage_ctrl

Overview:
Sequencer for one shared radix-2 DIT butterfly datapath that computes an in-place N-point FFT over a dual-port sample memory.
- Walks stages and butterflies in order.
- Issues read addresses for the butterfly pair and the twiddle ROM index.
- Delays the pair addresses to form write-back strobes.
- Inserts a flush gap between stages so stage s+1 never reads data that stage s has not yet written.
- Input data is already in bit-reversed order in memory; output ends in natural order.

Parameters:
LOG2N, 3, log2 of FFT size N (N=8 by default); legal range 2..12.
PIPE_LAT, 3, cycles from rd_en to matching wr_en (memory read latency plus butterfly latency); legal range 1..16.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request new FFT; sampled only in IDLE.
hold  input  1  pauses issue of new butterflies; in-flight ones complete.
busy  output  1  high from cycle after accepted start until done pulse inclusive.
done  output  1  one-cycle pulse when final write-back has completed.
rd_en  output  1  butterfly issue strobe.
rd_addr_a  output  LOG2N  upper-wing sample address.
rd_addr_b  output  LOG2N  lower-wing sample address.
tw_addr  output  LOG2N-1  twiddle ROM index, valid with rd_en.
wr_en  output  1  write-back strobe, PIPE_LAT cycles after its rd_en.
wr_addr_a  output  LOG2N  write address for butterfly output z1.
wr_addr_b  output  LOG2N  write address for butterfly output z2.
stage  output  clog2(LOG2N)  current stage index, 0-based.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset, asserted at any time including mid-FFT:
  - State goes to IDLE.
  - Every output is 0.
  - Delay line is cleared, so no spurious wr_en after release.
- States:
  - IDLE --start--> ISSUE. stage=0, j=0.
  - ISSUE: each cycle with hold=0, assert rd_en for butterfly j, then j++.
    - hold=1 gives rd_en=0 and j holds.
    - After issuing j=N/2-1, go to FLUSH.
  - FLUSH: stays until the cycle after the last wr_en of the stage, i.e. PIPE_LAT cycles after the last issue.
    - Then, if stage<LOG2N-1: stage++, j=0, go to ISSUE.
    - Otherwise go to DONE.
    - hold is ignored in FLUSH.
  - DONE: done=1 for one cycle, busy=1, then IDLE.
- start outside IDLE is ignored; there is no queuing.
- Addressing, with h=2^stage, g=j>>stage, k=j&(h-1):
  - rd_addr_a = g*2h + k.
  - rd_addr_b = rd_addr_a + h.
  - tw_addr = k << (LOG2N-1-stage).
  - All arithmetic is unsigned and width-exact; there is no wrap.
- rd_addr_*/tw_addr are registered with rd_en. Their values while rd_en=0 are don't-care but must hold the last value (no toggling).
- wr_en/wr_addr_a/wr_addr_b equal rd_en/rd_addr_a/rd_addr_b delayed exactly PIPE_LAT cycles, unaffected by hold.
- Latency with start sampled at cycle 0 and no hold:
  - First rd_en at cycle 1.
  - Each stage occupies N/2 issue cycles plus PIPE_LAT flush cycles.
  - done at cycle LOG2N*(N/2+PIPE_LAT)+1.
- rd_en and wr_en may be high in the same cycle within a stage. They never address the same location in that cycle, because reads and writes belong to the same stage.

Decomposition:
- Package fft_pkg holds:
  - the state enum: IDLE, ISSUE, FLUSH, DONE;
  - the default LOG2N/PIPE_LAT constants;
  - address width functions.
- One sub-module, fft_ctrl_delay: a PIPE_LAT-deep shift register with async reset carrying {valid, addr_a, addr_b}. It produces wr_en/wr_addr_*.
- Counter and address logic stays in the top module.

Test Plan:
- Default N=8, PIPE_LAT=3, start pulse at cycle 0, hold=0:
  - rd pairs stage0 (0,1)(2,3)(4,5)(6,7) tw 0,0,0,0;
  - stage1 (0,2)(1,3)(4,6)(5,7) tw 0,2,0,2;
  - stage2 (0,4)(1,5)(2,6)(3,7) tw 0,1,2,3;
  - done at cycle 22.
- Write-back check: every wr_en occurs exactly 3 cycles after its rd_en with identical addresses. No rd_en of stage s+1 occurs before the last wr_en of stage s; the first stage1 rd_en is at cycle 8.
- hold asserted for cycles 2-4 in stage0: the second butterfly (2,3) issues at cycle 5 and no addresses are skipped. In-flight wr_en for (0,1) still fires at cycle 4. done is at cycle 25.
- start re-pulsed at cycles 5 and 22: both ignored (busy=1). A start at cycle 23 in IDLE begins a new run with rd_en at cycle 24.
- rst_n low at cycle 10 mid-stage1:
  - all outputs 0 immediately;
  - no wr_en after release;
  - state IDLE;
  - a subsequent start runs a full, correct sequence.
- LOG2N=4, PIPE_LAT=1: 4 stages × 8 issues; stage3 tw sequence 0..7; done at cycle 4*(8+1)+1=37.
